load_store_unit: RTL and testbench

Memory-access (MA) stage load/store unit of the riscv-small pipeline. It consumes the decoded load/store operation (funct3 LOAD/STORE encodings), effective address and store data from the EX/MA register. It drives a single-outstanding request/grant/rvalid data-memory bus and returns aligned, sign/zero-extended load data to the write-back stage. While an access is in flight it stalls the pipeline, and it flags misaligned accesses without issuing them to the bus.

---
 rtl/riscv_definitions.sv | 38 +++
 rtl/lsu_align.sv | 74 +++++++
 rtl/load_store_unit.sv | 139 +++++++++++++
 tb/tb_load_store_unit.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_definitions.sv
// Shared riscv-small types: data bus width, LOAD/STORE funct3 encodings and
// the load/store unit state and bus structures.
package riscv_definitions;

  localparam int XLEN = 32;

  typedef logic [XLEN-1:0] dataBus_u;

  typedef enum logic [2:0] {
    LB  = 3'b000,
    LH  = 3'b001,
    LW  = 3'b010,
    LBU = 3'b100,
    LHU = 3'b101
  } funct3ITypeLOAD_e;

  typedef enum logic [2:0] {
    SB = 3'b000,
    SH = 3'b001,
    SW = 3'b010
  } funct3SType_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } lsuState_e;

  typedef struct packed {
    logic       req;
    logic       we;
    logic [3:0] be;
    dataBus_u   addr;
    dataBus_u   wdata;
  } memBus_s;

endpackage

// File: rtl/lsu_align.sv
// Byte-lane logic for the load/store unit: byte enables, store replication,
// load extraction/extension and misaligned/illegal-funct3 detection.
module lsu_align
  import riscv_definitions::*;
(
  input  logic       is_store_i,
  input  logic [2:0] funct3_i,
  input  logic [1:0] addr_lo_i,
  input  dataBus_u   wdata_i,
  input  dataBus_u   rdata_i,
  output logic [3:0] be_o,
  output dataBus_u   wdata_rep_o,
  output dataBus_u   ld_data_o,
  output logic       misaligned_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel     = rdata_i[7:0];
    half_sel     = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    be_o         = 4'b0000;
    wdata_rep_o  = wdata_i;
    ld_data_o    = rdata_i;
    misaligned_o = 1'b0;

    case (addr_lo_i)
      2'd0:    byte_sel = rdata_i[7:0];
      2'd1:    byte_sel = rdata_i[15:8];
      2'd2:    byte_sel = rdata_i[23:16];
      default: byte_sel = rdata_i[31:24];
    endcase

    if (is_store_i) begin
      case (funct3_i)
        SB: begin
          be_o        = 4'b0001 << addr_lo_i;
          wdata_rep_o = {4{wdata_i[7:0]}};
        end
        SH: begin
          be_o         = 4'b0011 << addr_lo_i;
          wdata_rep_o  = {2{wdata_i[15:0]}};
          misaligned_o = addr_lo_i[0];
        end
        SW: begin
          be_o         = 4'b1111;
          misaligned_o = |addr_lo_i;
        end
        // Unassigned store encodings never reach the bus.
        default: misaligned_o = 1'b1;
      endcase
    end else begin
      case (funct3_i)
        LB:  ld_data_o = {{24{byte_sel[7]}}, byte_sel};
        LBU: ld_data_o = {24'h0, byte_sel};
        LH: begin
          ld_data_o    = {{16{half_sel[15]}}, half_sel};
          misaligned_o = addr_lo_i[0];
        end
        LHU: begin
          ld_data_o    = {16'h0, half_sel};
          misaligned_o = addr_lo_i[0];
        end
        LW: begin
          ld_data_o    = rdata_i;
          misaligned_o = |addr_lo_i;
        end
        default: misaligned_o = 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/load_store_unit.sv
// MA-stage load/store unit: one outstanding req/gnt/rvalid access, stalls the
// pipeline while busy and traps misaligned or illegal accesses without a bus cycle.
module load_store_unit
  import riscv_definitions::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        op_valid,
  input  logic        op_is_store,
  input  logic [2:0]  op_funct3,
  input  logic [31:0] op_addr,
  input  logic [31:0] op_wdata,
  input  logic        flush,
  output logic        mem_req,
  input  logic        mem_gnt,
  output logic [31:0] mem_addr,
  output logic        mem_we,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic [31:0] ld_data,
  output logic        done,
  output logic        misaligned,
  output logic        stall,
  output lsuState_e   dbg_state
);

  lsuState_e  state_q;
  memBus_s    bus_q;
  logic [2:0] funct3_q;
  logic [1:0] lo_q;
  logic       kill_q;
  dataBus_u   ld_data_q;
  logic       done_q;
  logic       mis_q;

  logic       idle;
  logic [3:0] al_be;
  dataBus_u   al_wdata;
  dataBus_u   al_ld;
  logic       al_mis;

  assign idle = (state_q == IDLE);

  // In IDLE the aligner looks at the incoming op; afterwards at the captured one.
  lsu_align u_align (
    .is_store_i   (idle ? op_is_store : bus_q.we),
    .funct3_i     (idle ? op_funct3 : funct3_q),
    .addr_lo_i    (idle ? op_addr[1:0] : lo_q),
    .wdata_i      (op_wdata),
    .rdata_i      (mem_rdata),
    .be_o         (al_be),
    .wdata_rep_o  (al_wdata),
    .ld_data_o    (al_ld),
    .misaligned_o (al_mis)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      bus_q     <= '0;
      funct3_q  <= 3'd0;
      lo_q      <= 2'd0;
      kill_q    <= 1'b0;
      ld_data_q <= '0;
      done_q    <= 1'b0;
      mis_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      mis_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          kill_q <= 1'b0;
          if (op_valid && !flush) begin
            bus_q.we    <= op_is_store;
            bus_q.be    <= al_be;
            bus_q.addr  <= {op_addr[31:2], 2'b00};
            bus_q.wdata <= al_wdata;
            funct3_q    <= op_funct3;
            lo_q        <= op_addr[1:0];
            if (al_mis) begin
              state_q <= DONE;
              done_q  <= 1'b1;
              mis_q   <= 1'b1;
            end else begin
              state_q   <= REQ;
              bus_q.req <= 1'b1;
            end
          end
        end
        REQ: begin
          if (mem_gnt) begin
            bus_q.req <= 1'b0;
            if (bus_q.we) begin
              // A granted store is committed; a flush only hides its completion.
              state_q <= flush ? IDLE : DONE;
              done_q  <= !flush;
            end else begin
              state_q <= WAIT;
              kill_q  <= flush;
            end
          end else if (flush) begin
            state_q   <= IDLE;
            bus_q.req <= 1'b0;
          end
        end
        WAIT: begin
          if (mem_rvalid) begin
            if (kill_q || flush) begin
              state_q <= IDLE;
              kill_q  <= 1'b0;
            end else begin
              ld_data_q <= al_ld;
              state_q   <= DONE;
              done_q    <= 1'b1;
            end
          end else if (flush) begin
            kill_q <= 1'b1;
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign mem_req    = bus_q.req;
  assign mem_we     = bus_q.we;
  assign mem_be     = bus_q.be;
  assign mem_addr   = bus_q.addr;
  assign mem_wdata  = bus_q.wdata;
  assign ld_data    = ld_data_q;
  assign done       = done_q;
  assign misaligned = mis_q;
  assign stall      = op_valid && (state_q != DONE);
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed test-plan cases, random
// ops against an independent byte-lane model, flush and mid-transaction reset.
module tb_load_store_unit;
  import riscv_definitions::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        op_valid, op_is_store, flush;
  logic [2:0]  op_funct3;
  logic [31:0] op_addr, op_wdata;
  logic        mem_req, mem_gnt, mem_we, mem_rvalid;
  logic [31:0] mem_addr, mem_wdata, mem_rdata, ld_data;
  logic [3:0]  mem_be;
  logic        done, misaligned, stall;
  lsuState_e   dbg_state;

  int n_checks = 0;
  int n_pass   = 0;
  logic [32:0] exp_q[$];
  logic [31:0] last_ld;

  load_store_unit dut (
    .clk (clk), .rst_n (rst_n), .op_valid (op_valid), .op_is_store (op_is_store),
    .op_funct3 (op_funct3), .op_addr (op_addr), .op_wdata (op_wdata), .flush (flush),
    .mem_req (mem_req), .mem_gnt (mem_gnt), .mem_addr (mem_addr), .mem_we (mem_we),
    .mem_be (mem_be), .mem_wdata (mem_wdata), .mem_rvalid (mem_rvalid),
    .mem_rdata (mem_rdata), .ld_data (ld_data), .done (done), .misaligned (misaligned),
    .stall (stall), .dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  // Access size in bytes; 0 marks an unassigned encoding.
  function automatic int m_size(input logic st, input logic [2:0] f3);
    int sz;
    sz = 0;
    if (st) begin
      if (f3 == 3'd0) sz = 1;
      else if (f3 == 3'd1) sz = 2;
      else if (f3 == 3'd2) sz = 4;
    end else begin
      if (f3 == 3'd0 || f3 == 3'd4) sz = 1;
      else if (f3 == 3'd1 || f3 == 3'd5) sz = 2;
      else if (f3 == 3'd2) sz = 4;
    end
    return sz;
  endfunction

  function automatic logic m_mis(input logic st, input logic [2:0] f3, input logic [1:0] lo);
    int sz;
    sz = m_size(st, f3);
    return (sz == 0) || ((int'(lo) % sz) != 0);
  endfunction

  function automatic logic [3:0] m_be(input int sz, input logic [1:0] lo);
    logic [3:0] be;
    for (int k = 0; k < 4; k++) be[k] = (k >= int'(lo)) && (k < int'(lo) + sz);
    return be;
  endfunction

  function automatic logic [31:0] m_wdata(input int sz, input logic [31:0] wd);
    logic [31:0] r;
    for (int k = 0; k < 4; k++) r[8*k +: 8] = wd[8*(k % sz) +: 8];
    return r;
  endfunction

  function automatic logic [31:0] m_ld(input logic [2:0] f3, input logic [1:0] lo, input logic [31:0] rd);
    logic [31:0] sh;
    logic        sgn;
    int          sz;
    sz  = m_size(1'b0, f3);
    sh  = rd >> (8 * int'(lo));
    sgn = !f3[2];
    if (sz == 1) return {{24{sgn & sh[7]}}, sh[7:0]};
    if (sz == 2) return {{16{sgn & sh[15]}}, sh[15:0]};
    return sh;
  endfunction

  // Drives one op from IDLE and plays the bus with the given grant/rvalid delays.
  task automatic do_op(input logic st, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wd, input int gnt_dly, input int rv_dly,
                       input logic [31:0] rd);
    logic        mis;
    logic [32:0] e;
    int          cyc, req_cnt, gnt_cyc, exp_lat, sz;
    bit          seen_req, fin;
    mis = m_mis(st, f3, addr[1:0]);
    sz  = m_size(st, f3);
    if (!mis && !st) last_ld = m_ld(f3, addr[1:0], rd);
    exp_q.push_back({mis, last_ld});
    exp_lat = mis ? 1 : (st ? gnt_dly + 2 : gnt_dly + rv_dly + 3);
    op_valid = 1'b1; op_is_store = st; op_funct3 = f3; op_addr = addr; op_wdata = wd;
    #1 check("stall_first", 32'(stall), 32'd1);
    cyc = 0; req_cnt = 0; gnt_cyc = -1; seen_req = 0; fin = 0;
    while (!fin && cyc < 60) begin
      @(negedge clk);
      cyc++;
      mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = $urandom;
      if (mem_req) begin
        if (gnt_cyc >= 0 || mis) check("req_unexpected", 32'(mem_req), 32'd0);
        else begin
          if (!seen_req) begin
            seen_req = 1;
            check("mem_addr", mem_addr, {addr[31:2], 2'b00});
            check("mem_we", 32'(mem_we), 32'(st));
            if (st) begin
              check("mem_be", 32'(mem_be), 32'(m_be(sz, addr[1:0])));
              check("mem_wdata", mem_wdata, m_wdata(sz, wd));
            end
          end
          req_cnt++;
          if (req_cnt > gnt_dly) begin mem_gnt = 1'b1; gnt_cyc = cyc; end
        end
      end
      if (!st && gnt_cyc >= 0 && cyc == gnt_cyc + 1 + rv_dly) begin
        mem_rvalid = 1'b1; mem_rdata = rd;
      end
      if (done) begin
        fin = 1;
        if (exp_q.size() == 0) check("sb_underflow", 32'(exp_q.size()), 32'd1);
        else begin
          e = exp_q.pop_front();
          check("ld_data", ld_data, e[31:0]);
          check("misaligned", 32'(misaligned), 32'(e[32]));
        end
        check("latency", 32'(cyc), 32'(exp_lat));
        check("stall_done", 32'(stall), 32'd0);
        op_valid = 1'b0;
      end else begin
        check("stall_busy", 32'(stall), 32'd1);
        check("mis_no_done", 32'(misaligned), 32'd0);
      end
    end
    check("done_seen", 32'(fin), 32'd1);
    check("req_issued", 32'(seen_req), 32'(!mis));
    op_valid = 1'b0;
    @(negedge clk);
    mem_gnt = 1'b0; mem_rvalid = 1'b0;
    check("done_pulse", 32'(done), 32'd0);
    check("back_idle", 32'(dbg_state), 32'(IDLE));
  endtask

  initial begin
    logic st;
    logic [2:0] f3;
    rst_n = 1'b0; op_valid = 1'b0; op_is_store = 1'b0; op_funct3 = 3'd0;
    op_addr = '0; op_wdata = '0; flush = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b0;
    mem_rdata = '0; last_ld = '0;
    repeat (2) @(negedge clk);
    check("rst_req", 32'(mem_req), 32'd0);
    check("rst_be", 32'(mem_be), 32'd0);
    check("rst_ld", ld_data, 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_state", 32'(dbg_state), 32'(IDLE));
    rst_n = 1'b1;
    @(negedge clk);

    do_op(1'b1, 3'd2, 32'h100, 32'hDEADBEEF, 2, 0, '0);
    check("sw_be", 32'(mem_be), 32'hF);
    do_op(1'b1, 3'd0, 32'h203, 32'h000000A5, 0, 0, '0);
    check("sb_be", 32'(mem_be), 32'h8);
    check("sb_wdata", mem_wdata, 32'hA5A5A5A5);
    check("sb_addr", mem_addr, 32'h200);
    do_op(1'b0, 3'd0, 32'h301, 32'h0, 0, 0, 32'h00008000);
    check("lb_ext", ld_data, 32'hFFFFFF80);
    do_op(1'b0, 3'd4, 32'h301, 32'h0, 1, 2, 32'h00008000);
    check("lbu_ext", ld_data, 32'h00000080);
    do_op(1'b0, 3'd1, 32'h302, 32'h0, 0, 1, 32'h80010000);
    check("lh_ext", ld_data, 32'hFFFF8001);
    do_op(1'b0, 3'd2, 32'h402, 32'h0, 0, 0, 32'h0);
    do_op(1'b0, 3'd3, 32'h404, 32'h0, 0, 0, 32'h0);
    do_op(1'b1, 3'd5, 32'h408, 32'h1, 0, 0, 32'h0);

    // Load granted, flushed in WAIT: response consumed silently.
    op_valid = 1'b1; op_is_store = 1'b0; op_funct3 = 3'd2; op_addr = 32'h500;
    @(negedge clk);
    check("fl_req", 32'(mem_req), 32'd1);
    mem_gnt = 1'b1;
    @(negedge clk);
    mem_gnt = 1'b0;
    check("fl_wait", 32'(dbg_state), 32'(WAIT));
    flush = 1'b1; op_valid = 1'b0;
    @(negedge clk);
    flush = 1'b0;
    @(negedge clk);
    check("fl_hold", 32'(dbg_state), 32'(WAIT));
    check("fl_no_req", 32'(mem_req), 32'd0);
    @(negedge clk);
    mem_rvalid = 1'b1; mem_rdata = 32'h12345678;
    @(negedge clk);
    mem_rvalid = 1'b0;
    check("fl_no_done", 32'(done), 32'd0);
    check("fl_ld_keep", ld_data, last_ld);
    check("fl_idle", 32'(dbg_state), 32'(IDLE));
    do_op(1'b0, 3'd5, 32'h512, 32'h0, 0, 0, 32'hBEEF0000);

    // Flush in REQ before grant drops the request.
    op_valid = 1'b1; op_is_store = 1'b1; op_funct3 = 3'd2; op_addr = 32'h600;
    @(negedge clk);
    check("flr_req", 32'(mem_req), 32'd1);
    flush = 1'b1; op_valid = 1'b0;
    @(negedge clk);
    flush = 1'b0;
    check("flr_drop", 32'(mem_req), 32'd0);
    check("flr_done", 32'(done), 32'd0);
    check("flr_idle", 32'(dbg_state), 32'(IDLE));

    for (int i = 0; i < 24; i++) begin
      st = 1'($urandom_range(0, 1));
      f3 = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 3) != 0) f3 = st ? 3'($urandom_range(0, 2)) : 3'($urandom_range(0, 2));
      if (!st && $urandom_range(0, 2) == 0) f3[2] = (f3 != 3'd2);
      do_op(st, f3, {22'h0, 8'($urandom_range(0, 255)), 2'($urandom_range(0, 3))},
            $urandom, $urandom_range(0, 3), $urandom_range(0, 3), $urandom);
    end

    // Reset while a request is pending.
    op_valid = 1'b1; op_is_store = 1'b1; op_funct3 = 3'd2; op_addr = 32'h700; op_wdata = 32'h55;
    @(negedge clk);
    check("rr_req", 32'(mem_req), 32'd1);
    #2 rst_n = 1'b0; op_valid = 1'b0;
    #1;
    check("rr_req0", 32'(mem_req), 32'd0);
    check("rr_addr0", mem_addr, 32'd0);
    check("rr_wdata0", mem_wdata, 32'd0);
    check("rr_we0", 32'(mem_we), 32'd0);
    check("rr_ld0", ld_data, 32'd0);
    check("rr_state", 32'(dbg_state), 32'(IDLE));
    last_ld = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    do_op(1'b0, 3'd0, 32'h7FF, 32'h0, 1, 0, 32'h7F000000);

    check("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
